// File: rtl/vga_sram_arbiter.sv
// Arbiter sharing one single-port framebuffer SRAM between the VGA fetch path
// and the CPU bus. One access is outstanding at a time and the grant is registered.
module vga_sram_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              vga_urgent,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_sel,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [3:0]        sram_sel,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_busy,
  output logic              grant_cpu
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              sram_en_q, sram_en_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic [3:0]        sram_sel_q, sram_sel_d;
  logic              vga_ack_q, vga_ack_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              grant_cpu_q, grant_cpu_d;
  logic              grant_v, grant_c;

  always_comb begin
    grant_v = 1'b0;
    grant_c = 1'b0;
    if (state_q == S_IDLE && !sram_busy) begin
      if (vga_req && cpu_req) begin
        // Urgent VGA wins unless the CPU has waited out its starvation budget;
        // otherwise alternate, using the last owner as the round-robin pointer.
        if (vga_urgent) grant_c = (starve_q == STV_W'(STARVE_MAX));
        else            grant_c = !grant_cpu_q;
        grant_v = !grant_c;
      end else begin
        grant_c = cpu_req;
        grant_v = vga_req;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    starve_d     = starve_q;
    sram_en_d    = sram_en_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    sram_sel_d   = sram_sel_q;
    vga_ack_d    = 1'b0;
    cpu_ack_d    = 1'b0;
    vga_rdata_d  = vga_rdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    grant_cpu_d  = grant_cpu_q;

    case (state_q)
      S_IDLE: begin
        if (grant_c || grant_v) begin
          state_d     = S_ISSUE;
          sram_en_d   = 1'b1;
          grant_cpu_d = grant_c;
          if (grant_c) begin
            sram_we_d    = cpu_we;
            sram_addr_d  = cpu_addr;
            sram_wdata_d = cpu_wdata;
            sram_sel_d   = cpu_we ? cpu_sel : 4'hF;
          end else begin
            sram_we_d    = 1'b0;
            sram_addr_d  = vga_addr;
            sram_wdata_d = '0;
            sram_sel_d   = 4'hF;
          end
        end
      end
      S_ISSUE: begin
        if (!sram_busy) begin
          sram_en_d = 1'b0;
          if (sram_we_q) begin
            state_d   = S_ACK;
            cpu_ack_d = grant_cpu_q;
            vga_ack_d = !grant_cpu_q;
          end else begin
            state_d = S_WAIT;
            lat_d   = LAT_W'(RD_LAT - 1);
          end
        end
      end
      S_WAIT: begin
        if (lat_q != '0) begin
          lat_d = lat_q - LAT_W'(1);
        end else if (!sram_busy) begin
          state_d = S_ACK;
          if (grant_cpu_q) begin
            cpu_rdata_d = sram_rdata;
            cpu_ack_d   = 1'b1;
          end else begin
            vga_rdata_d = sram_rdata;
            vga_ack_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!cpu_req || grant_c) begin
      starve_d = '0;
    end else if (grant_v && starve_q != STV_W'(STARVE_MAX)) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lat_q        <= '0;
      starve_q     <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_sel_q   <= '0;
      vga_ack_q    <= 1'b0;
      cpu_ack_q    <= 1'b0;
      vga_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
      grant_cpu_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      starve_q     <= starve_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_sel_q   <= sram_sel_d;
      vga_ack_q    <= vga_ack_d;
      cpu_ack_q    <= cpu_ack_d;
      vga_rdata_q  <= vga_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      grant_cpu_q  <= grant_cpu_d;
    end
  end

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_sel   = sram_sel_q;
  assign vga_ack    = vga_ack_q;
  assign cpu_ack    = cpu_ack_q;
  assign vga_rdata  = vga_rdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign grant_cpu  = grant_cpu_q;

endmodule
